// File: rtl/tconv_tile_scheduler_pkg.sv
// Shared definitions for the transpose-convolution tile scheduler:
// state encoding and schedule-length constants.
package tconv_sched_defs;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_W_RD  = 3'd1,
    S_W_LD  = 3'd2,
    S_IF_RD = 3'd3,
    S_IF_LD = 3'd4,
    S_PSUM  = 3'd5,
    S_DRAIN = 3'd6,
    S_DONE  = 3'd7
  } sched_state_e;

  // One drain cycle per PE column of the array.
  localparam int DRAIN_LEN = 16;

  // Cycles spent on one ifmap element: IF_RD + IF_LD + PSUM + drain.
  localparam int ELEM_PERIOD = DRAIN_LEN + 3;

endpackage

// File: rtl/tconv_tile_scheduler.sv
// Tile sequencer for the transpose-convolution datapath. Loads one weight
// row into all PEs, then for each ifmap element reads, broadcasts, computes
// partial sums and drains NUM_BRAMS results into the accumulator.
// All outputs are registered and decoded from the next state, so each
// state's controls are visible in the same cycle the state is occupied.
module tconv_tile_scheduler
  import tconv_sched_defs::*;
#(
  parameter int NUM_BRAMS = DRAIN_LEN,
  parameter int W_ADDR_W  = 10,
  parameter int I_ADDR_W  = 10
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            start,
  input  logic                            abort,
  input  logic [W_ADDR_W-1:0]             cfg_w_base,
  input  logic [I_ADDR_W-1:0]             cfg_if_base,
  input  logic [I_ADDR_W-1:0]             cfg_num_ifmap,
  input  logic [3:0]                      cfg_if_bram,
  output logic                            busy,
  output logic                            done,
  output logic [NUM_BRAMS-1:0]            w_re,
  output logic [NUM_BRAMS*W_ADDR_W-1:0]   w_addr_rd_flat,
  output logic [NUM_BRAMS-1:0]            if_re,
  output logic [NUM_BRAMS*I_ADDR_W-1:0]   if_addr_rd_flat,
  output logic [3:0]                      ifmap_sel,
  output logic [NUM_BRAMS-1:0]            en_weight_load,
  output logic [NUM_BRAMS-1:0]            en_ifmap_load,
  output logic [NUM_BRAMS-1:0]            en_psum,
  output logic [NUM_BRAMS-1:0]            clear_psum,
  output logic [NUM_BRAMS-1:0]            en_output,
  output logic [4:0]                      done_select
);

  localparam logic [4:0] K_LAST = 5'(NUM_BRAMS - 1);

  sched_state_e          state_q, state_d;
  logic [I_ADDR_W-1:0]   i_q, i_d;
  logic [4:0]            k_q, k_d;
  logic                  load_cfg;
  logic [I_ADDR_W:0]     i_inc;

  logic [W_ADDR_W-1:0]   w_base_q, w_base_d;
  logic [I_ADDR_W-1:0]   if_base_q, if_base_d;
  logic [I_ADDR_W-1:0]   num_q, num_d;
  logic [3:0]            if_bram_q, if_bram_d;

  // Element index plus one, one bit wider so the last-element compare
  // cannot wrap even at the maximum tile size.
  assign i_inc = {1'b0, i_q} + {{I_ADDR_W{1'b0}}, 1'b1};

  // A start in IDLE takes the live cfg values so the first decoded
  // outputs already reflect the new tile.
  assign w_base_d  = load_cfg ? cfg_w_base    : w_base_q;
  assign if_base_d = load_cfg ? cfg_if_base   : if_base_q;
  assign num_d     = load_cfg ? cfg_num_ifmap : num_q;
  assign if_bram_d = load_cfg ? cfg_if_bram   : if_bram_q;

  // Next-state, element index and drain counter; abort overrides all.
  always_comb begin
    state_d  = state_q;
    i_d      = i_q;
    k_d      = k_q;
    load_cfg = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start && !abort) begin
          load_cfg = 1'b1;
          i_d      = '0;
          state_d  = S_W_RD;
        end
      end
      S_W_RD:  state_d = S_W_LD;
      S_W_LD:  state_d = (num_q != '0) ? S_IF_RD : S_DONE;
      S_IF_RD: state_d = S_IF_LD;
      S_IF_LD: state_d = S_PSUM;
      S_PSUM: begin
        state_d = S_DRAIN;
        k_d     = '0;
      end
      S_DRAIN: begin
        k_d = k_q + 5'd1;
        if (k_q == K_LAST) begin
          i_d     = i_inc[I_ADDR_W-1:0];
          state_d = (i_inc < {1'b0, num_q}) ? S_IF_RD : S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (abort && (state_q != S_IDLE)) begin
      state_d = S_IDLE;
    end
  end

  // ---- output decode from next state ----
  logic                          in_w_rd, in_w_ld, in_if_rd, in_if_ld;
  logic                          in_psum, in_drain, in_done;
  logic [I_ADDR_W-1:0]           if_addr_d;
  int                            if_slot;
  logic [NUM_BRAMS-1:0]          w_re_d, if_re_d, en_output_d;
  logic [NUM_BRAMS*W_ADDR_W-1:0] w_addr_d;
  logic [NUM_BRAMS*I_ADDR_W-1:0] if_addr_flat_d;
  logic [3:0]                    ifmap_sel_d;
  logic [4:0]                    done_select_d;

  assign in_w_rd  = (state_d == S_W_RD);
  assign in_w_ld  = (state_d == S_W_LD);
  assign in_if_rd = (state_d == S_IF_RD);
  assign in_if_ld = (state_d == S_IF_LD);
  assign in_psum  = (state_d == S_PSUM);
  assign in_drain = (state_d == S_DRAIN);
  assign in_done  = (state_d == S_DONE);

  // Address wraps modulo 2^I_ADDR_W by construction.
  assign if_addr_d = if_base_d + i_d;
  assign if_slot   = int'(if_bram_d) % NUM_BRAMS;

  assign ifmap_sel_d   = (in_if_rd || in_if_ld || in_psum) ? if_bram_d : '0;
  assign done_select_d = in_drain ? k_d : '0;

  for (genvar j = 0; j < NUM_BRAMS; j++) begin : g_lane
    assign w_re_d[j]                          = in_w_rd;
    assign w_addr_d[j*W_ADDR_W +: W_ADDR_W]   = in_w_rd ? w_base_d : '0;
    assign if_re_d[j]                         = in_if_rd && (if_slot == j);
    assign if_addr_flat_d[j*I_ADDR_W +: I_ADDR_W] =
      (in_if_rd && (if_slot == j)) ? if_addr_d : '0;
    assign en_output_d[j]                     = in_drain && (k_d == 5'(j));
  end

  // Control state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      i_q     <= '0;
      k_q     <= '0;
    end else begin
      state_q <= state_d;
      i_q     <= i_d;
      k_q     <= k_d;
    end
  end

  // Tile configuration, captured only on an accepted start.
  always_ff @(posedge clk) begin
    w_base_q  <= w_base_d;
    if_base_q <= if_base_d;
    num_q     <= num_d;
    if_bram_q <= if_bram_d;
  end

  // Registered datapath controls; cleared by reset and by any return to IDLE.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy            <= 1'b0;
      done            <= 1'b0;
      w_re            <= '0;
      w_addr_rd_flat  <= '0;
      if_re           <= '0;
      if_addr_rd_flat <= '0;
      ifmap_sel       <= '0;
      en_weight_load  <= '0;
      en_ifmap_load   <= '0;
      en_psum         <= '0;
      clear_psum      <= '0;
      en_output       <= '0;
      done_select     <= '0;
    end else begin
      busy            <= (state_d != S_IDLE);
      done            <= in_done;
      w_re            <= w_re_d;
      w_addr_rd_flat  <= w_addr_d;
      if_re           <= if_re_d;
      if_addr_rd_flat <= if_addr_flat_d;
      ifmap_sel       <= ifmap_sel_d;
      en_weight_load  <= {NUM_BRAMS{in_w_ld}};
      en_ifmap_load   <= {NUM_BRAMS{in_if_ld}};
      en_psum         <= {NUM_BRAMS{in_psum}};
      clear_psum      <= {NUM_BRAMS{in_if_rd}};
      en_output       <= en_output_d;
      done_select     <= done_select_d;
    end
  end

endmodule

// File: tb/tb_tconv_tile_scheduler.sv
// Bench for tconv_tile_scheduler: a table of tile configurations, each run
// against a cycle-indexed timing model whose expected outputs are queued at
// start and popped one per cycle.
module tb_tconv_tile_scheduler;

  logic         clk = 1'b0;
  logic         rst, start, abort;
  logic [9:0]   cfg_w_base, cfg_if_base, cfg_num_ifmap;
  logic [3:0]   cfg_if_bram;
  logic         busy, done;
  logic [15:0]  w_re, if_re;
  logic [159:0] w_addr_rd_flat, if_addr_rd_flat;
  logic [3:0]   ifmap_sel;
  logic [15:0]  en_weight_load, en_ifmap_load, en_psum, clear_psum, en_output;
  logic [4:0]   done_select;

  tconv_tile_scheduler dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .cfg_w_base(cfg_w_base), .cfg_if_base(cfg_if_base),
    .cfg_num_ifmap(cfg_num_ifmap), .cfg_if_bram(cfg_if_bram),
    .busy(busy), .done(done), .w_re(w_re), .w_addr_rd_flat(w_addr_rd_flat),
    .if_re(if_re), .if_addr_rd_flat(if_addr_rd_flat), .ifmap_sel(ifmap_sel),
    .en_weight_load(en_weight_load), .en_ifmap_load(en_ifmap_load),
    .en_psum(en_psum), .clear_psum(clear_psum), .en_output(en_output),
    .done_select(done_select)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic         busy;
    logic         done;
    logic [15:0]  w_re;
    logic [159:0] w_addr;
    logic [15:0]  if_re;
    logic [159:0] if_addr;
    logic [3:0]   sel;
    logic [15:0]  ewl;
    logic [15:0]  eil;
    logic [15:0]  eps;
    logic [15:0]  clr;
    logic [15:0]  eout;
    logic [4:0]   dsel;
  } obs_t;

  typedef struct {
    int w_base;
    int if_base;
    int n;
    int bram;
    int inject;    // pulse start during PSUM and DONE
    int kill_at;   // cycle at which abort/rst is raised, 0 = none
    int kill_rst;  // 1 = rst, 0 = abort
    int exp_done;  // cycle of done pulse, -1 = none
    int exp_busy;  // number of busy cycles
  } tile_t;

  int   checks = 0;
  int   errors = 0;
  obs_t sb[$];

  // Expected outputs for cycle c after the start edge, from the timing table.
  function automatic obs_t model(int c, tile_t t);
    obs_t o;
    int   e, p;
    o = '0;
    if (c < 1) return o;
    if (t.kill_at > 0 && c > t.kill_at) return o;
    if (c > 19 * t.n + 3) return o;
    o.busy = 1'b1;
    if (c == 1) begin
      o.w_re = '1;
      for (int j = 0; j < 16; j++) o.w_addr[j*10 +: 10] = 10'(t.w_base);
    end else if (c == 2) begin
      o.ewl = '1;
    end else if (c == 19 * t.n + 3) begin
      o.done = 1'b1;
    end else begin
      e = (c - 3) / 19;
      p = (c - 3) % 19;
      case (p)
        0: begin
          o.if_re = 16'(1) << t.bram;
          o.if_addr[t.bram*10 +: 10] = 10'((t.if_base + e) % 1024);
          o.clr = '1;
          o.sel = 4'(t.bram);
        end
        1: begin o.eil = '1; o.sel = 4'(t.bram); end
        2: begin o.eps = '1; o.sel = 4'(t.bram); end
        default: begin
          o.dsel = 5'(p - 3);
          o.eout = 16'(1) << (p - 3);
        end
      endcase
    end
    return o;
  endfunction

  function automatic obs_t sample();
    obs_t o;
    o.busy = busy;           o.done = done;
    o.w_re = w_re;           o.w_addr = w_addr_rd_flat;
    o.if_re = if_re;         o.if_addr = if_addr_rd_flat;
    o.sel = ifmap_sel;       o.ewl = en_weight_load;
    o.eil = en_ifmap_load;   o.eps = en_psum;
    o.clr = clear_psum;      o.eout = en_output;
    o.dsel = done_select;
    return o;
  endfunction

  task automatic chk_obs(input string nm, input int c);
    obs_t exp_o, act_o;
    exp_o = sb.pop_front();
    act_o = sample();
    checks++;
    if (act_o !== exp_o) begin
      errors++;
      $display("FAIL %s cyc %0d outputs act=%h exp=%h", nm, c, act_o, exp_o);
    end
  endtask

  task automatic chk_int(input string nm, input int act, input int exp_v);
    checks++;
    if (act != exp_v) begin
      errors++;
      $display("FAIL %s act=%0d exp=%0d", nm, act, exp_v);
    end
  endtask

  task automatic run_tile(input tile_t t, input string nm);
    int done_cyc, busy_cnt, tlen;
    done_cyc = -1;
    busy_cnt = 0;
    tlen = (t.kill_at > 0) ? t.kill_at + 3 : 19 * t.n + 4;
    @(negedge clk);
    cfg_w_base    = 10'(t.w_base);
    cfg_if_base   = 10'(t.if_base);
    cfg_num_ifmap = 10'(t.n);
    cfg_if_bram   = 4'(t.bram);
    start = 1'b1;
    for (int c = 1; c <= tlen; c++) sb.push_back(model(c, t));
    for (int c = 1; c <= tlen; c++) begin
      @(negedge clk);
      if (busy) busy_cnt++;
      if (done && done_cyc < 0) done_cyc = c;
      chk_obs(nm, c);
      // Scramble cfg to show only the start-time values matter.
      cfg_w_base    = 10'($urandom);
      cfg_if_base   = 10'($urandom);
      cfg_num_ifmap = 10'($urandom);
      cfg_if_bram   = 4'($urandom);
      start = (t.inject != 0) && (c == 5 || c == 19 * t.n + 3);
      abort = (t.kill_at > 0) && (t.kill_rst == 0) && (c == t.kill_at);
      rst   = (t.kill_at > 0) && (t.kill_rst != 0) && (c == t.kill_at);
    end
    chk_int({nm, " done_cycle"}, done_cyc, t.exp_done);
    chk_int({nm, " busy_cycles"}, busy_cnt, t.exp_busy);
  endtask

  tile_t tbl[8];
  tile_t idle_t;

  initial begin
    tbl[0] = '{5,    8,    1, 3,  0, 0,  0, 22, 22};
    tbl[1] = '{7,    1022, 3, 0,  0, 0,  0, 60, 60};
    tbl[2] = '{1023, 0,    0, 5,  0, 0,  0, 3,  3};
    tbl[3] = '{2,    100,  4, 9,  0, 30, 0, -1, 30};
    tbl[4] = '{11,   500,  1, 12, 0, 0,  0, 22, 22};
    tbl[5] = '{3,    50,   2, 15, 1, 0,  0, 41, 41};
    tbl[6] = '{9,    20,   2, 6,  0, 10, 1, -1, 10};
    tbl[7] = '{1,    1,    1, 1,  0, 0,  0, 22, 22};
    idle_t = '{0, 0, 0, 0, 0, 0, 0, 0, 0};

    rst = 1'b1; start = 1'b0; abort = 1'b0;
    cfg_w_base = '0; cfg_if_base = '0; cfg_num_ifmap = '0; cfg_if_bram = '0;
    repeat (3) @(negedge clk);
    sb.push_back(model(0, idle_t));
    chk_obs("reset", 0);
    rst = 1'b0;

    // abort takes priority over a simultaneous start in IDLE.
    @(negedge clk);
    start = 1'b1; abort = 1'b1; cfg_num_ifmap = 10'd1;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    sb.push_back(model(0, idle_t));
    chk_obs("abort_over_start", 1);
    @(negedge clk);
    sb.push_back(model(0, idle_t));
    chk_obs("abort_over_start_hold", 2);

    for (int r = 0; r < 8; r++) begin
      run_tile(tbl[r], $sformatf("tile%0d", r));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
